// File: rtl/mem_txn_scheduler_if.sv
// mem_txn_scheduler_if
// Groups the two instruction-queue handshakes and the shared memory bus used
// by mem_txn_scheduler.
//   instr_aes/valid_in_aes/ready_out_aes : AES queue head handshake
//   instr_sha/valid_in_sha/ready_out_sha : SHA queue head handshake
//   bus_req/bus_addr/bus_op/bus_ack      : shared memory bus
//                                          (op 00 key rd, 01 text rd, 10 dest wr)
// Modports:
//   master : scheduler side (drives ready and bus request fields)
//   slave  : environment side (drives queue heads and bus_ack)
interface mem_txn_scheduler_if #(
  parameter int ADDRW   = 24,
  parameter int OPCODEW = 2
);
  localparam int INSTRW = 3*ADDRW + OPCODEW;

  logic [INSTRW-1:0] instr_aes;
  logic              valid_in_aes;
  logic              ready_out_aes;
  logic [INSTRW-1:0] instr_sha;
  logic              valid_in_sha;
  logic              ready_out_sha;
  logic              bus_req;
  logic [ADDRW-1:0]  bus_addr;
  logic [1:0]        bus_op;
  logic              bus_ack;

  modport master (
    input  instr_aes, valid_in_aes, instr_sha, valid_in_sha, bus_ack,
    output ready_out_aes, ready_out_sha, bus_req, bus_addr, bus_op
  );

  modport slave (
    output instr_aes, valid_in_aes, instr_sha, valid_in_sha, bus_ack,
    input  ready_out_aes, ready_out_sha, bus_req, bus_addr, bus_op
  );
endinterface

// File: rtl/mem_txn_scheduler.sv
// mem_txn_scheduler
// Arbitrates between an AES and a SHA instruction queue, then sequences one
// transaction at a time: key read (AES only), text read, engine start, wait
// for engine done, destination write. Instruction layout, MSB first:
// {opcode, key_addr, text_addr, dest_addr}.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   io (master)       : queue handshakes and shared memory bus
//   aes_start/sha_start : one-cycle engine start pulses (registered)
//   aes_done/sha_done : engine completion inputs
//   eng_mode          : opcode[1] of the current transaction (registered)
//   busy              : high in every state but IDLE (registered)
//   cur_sha           : current transaction came from the SHA port (registered)
//   err               : sticky port/opcode mismatch flag, cleared by reset only
module mem_txn_scheduler #(
  parameter int ADDRW   = 24,
  parameter int OPCODEW = 2
) (
  input  logic                clk,
  input  logic                rst,
  mem_txn_scheduler_if.master io,
  output logic                aes_start,
  output logic                sha_start,
  input  logic                aes_done,
  input  logic                sha_done,
  output logic                eng_mode,
  output logic                busy,
  output logic                cur_sha,
  output logic                err
);
  localparam int INSTRW = 3*ADDRW + OPCODEW;

  typedef enum logic [2:0] {IDLE, KEY, TEXT, START, WAIT, DEST} state_t;

  state_t            state_q, state_d;
  logic [ADDRW-1:0]  key_q, key_d, text_q, text_d, dest_q, dest_d;
  logic              cur_sha_q, cur_sha_d;
  logic              last_sha_q, last_sha_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              eng_mode_q, eng_mode_d;
  logic              aes_start_q, aes_start_d;
  logic              sha_start_q, sha_start_d;
  logic              grant_aes, grant_sha;
  logic [INSTRW-1:0] sel_instr;

  // Grant only exists in IDLE and never while reset is held.
  // last_sha_q=1 means the AES port wins the next tie.
  always_comb begin
    grant_aes = 1'b0;
    grant_sha = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (io.valid_in_aes && io.valid_in_sha) begin
        grant_aes = last_sha_q;
        grant_sha = !last_sha_q;
      end else begin
        grant_aes = io.valid_in_aes;
        grant_sha = io.valid_in_sha;
      end
    end
    io.ready_out_aes = grant_aes;
    io.ready_out_sha = grant_sha;
    sel_instr = grant_sha ? io.instr_sha : io.instr_aes;
  end

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    text_d     = text_q;
    dest_d     = dest_q;
    cur_sha_d  = cur_sha_q;
    last_sha_d = last_sha_q;
    err_d      = err_q;
    eng_mode_d = eng_mode_q;
    case (state_q)
      IDLE: begin
        if (grant_aes || grant_sha) begin
          key_d      = sel_instr[3*ADDRW-1 -: ADDRW];
          text_d     = sel_instr[2*ADDRW-1 -: ADDRW];
          dest_d     = sel_instr[ADDRW-1:0];
          cur_sha_d  = grant_sha;
          last_sha_d = grant_sha;
          // opcode[0] must name the port it arrived on; otherwise drop it.
          if (sel_instr[3*ADDRW] != grant_sha) begin
            err_d = 1'b1;
          end else begin
            eng_mode_d = sel_instr[3*ADDRW+1];
            state_d    = grant_sha ? TEXT : KEY;
          end
        end
      end
      KEY:     if (io.bus_ack) state_d = TEXT;
      TEXT:    if (io.bus_ack) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (cur_sha_q ? sha_done : aes_done) state_d = DEST;
      DEST:    if (io.bus_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Registered outputs are computed from the next state so they line up
    // with the state they describe.
    busy_d      = (state_d != IDLE);
    aes_start_d = (state_d == START) && !cur_sha_d;
    sha_start_d = (state_d == START) && cur_sha_d;
  end

  always_comb begin
    io.bus_req  = 1'b0;
    io.bus_addr = '0;
    io.bus_op   = 2'b00;
    case (state_q)
      KEY:  begin io.bus_req = 1'b1; io.bus_addr = key_q;  io.bus_op = 2'b00; end
      TEXT: begin io.bus_req = 1'b1; io.bus_addr = text_q; io.bus_op = 2'b01; end
      DEST: begin io.bus_req = 1'b1; io.bus_addr = dest_q; io.bus_op = 2'b10; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      text_q      <= '0;
      dest_q      <= '0;
      cur_sha_q   <= 1'b0;
      last_sha_q  <= 1'b1;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      eng_mode_q  <= 1'b0;
      aes_start_q <= 1'b0;
      sha_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      text_q      <= text_d;
      dest_q      <= dest_d;
      cur_sha_q   <= cur_sha_d;
      last_sha_q  <= last_sha_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      eng_mode_q  <= eng_mode_d;
      aes_start_q <= aes_start_d;
      sha_start_q <= sha_start_d;
    end
  end

  assign aes_start = aes_start_q;
  assign sha_start = sha_start_q;
  assign eng_mode  = eng_mode_q;
  assign busy      = busy_q;
  assign cur_sha   = cur_sha_q;
  assign err       = err_q;
endmodule
